// File: rtl/pipelined_adder_tree_pkg.sv
// adder_tree_pkg: shared constants and helpers for the pipelined adder tree (ACC_BITS used when ADDER_TREE_ACCUM_EN is defined)
package adder_tree_pkg;
  localparam int ACC_BITS = 8;
  function automatic int stage_ops(input int n_inputs, input int k);
    return n_inputs >> k;
  endfunction
  function automatic logic ext(input logic value, input bit signed_mode);
    return signed_mode & value;
  endfunction
endpackage

// File: rtl/pipelined_adder_tree_if.sv
// pipelined_adder_tree_if: operand/sum valid-ready bundle; ADDER_TREE_ACCUM_EN adds in_last and widens out_sum
interface pipelined_adder_tree_if #(
  parameter int N_INPUTS = 8,
  parameter int IN_WIDTH = 23
);
  import adder_tree_pkg::*;
`ifdef ADDER_TREE_ACCUM_EN
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(N_INPUTS) + ACC_BITS;
  logic in_last;
`else
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(N_INPUTS);
`endif
  logic                         in_valid;
  logic                         in_ready;
  logic [N_INPUTS*IN_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_WIDTH-1:0]         out_sum;
  modport master (
    output in_valid, in_data, out_ready,
`ifdef ADDER_TREE_ACCUM_EN
    in_last,
`endif
    input in_ready, out_valid, out_sum
  );
  modport slave (
    input in_valid, in_data, out_ready,
`ifdef ADDER_TREE_ACCUM_EN
    in_last,
`endif
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/pipelined_adder_tree_level.sv
// adder_tree_level: one registered tree level summing operand pairs with one bit of growth (ADDER_TREE_ACCUM_EN carries last)
module adder_tree_level #(
  parameter int N_IN   = 2,
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       advance,
  input  logic [N_IN*W-1:0]          i_data,
  input  logic                       i_valid,
`ifdef ADDER_TREE_ACCUM_EN
  input  logic                       i_last,
  output logic                       o_last,
`endif
  output logic [(N_IN/2)*(W+1)-1:0]  o_data,
  output logic                       o_valid
);
  import adder_tree_pkg::*;
  logic [(N_IN/2)*(W+1)-1:0] w_sum;
  logic [W-1:0]              w_a;
  logic [W-1:0]              w_b;
  // pairwise sums of operands 2j and 2j+1, each extended by one bit
  always_comb begin
    w_sum = '0;
    w_a   = '0;
    w_b   = '0;
    for (int j = 0; j < N_IN/2; j++) begin
      w_a = i_data[2*j*W +: W];
      w_b = i_data[(2*j+1)*W +: W];
      w_sum[j*(W+1) +: W+1] = {ext(w_a[W-1], SIGNED), w_a} + {ext(w_b[W-1], SIGNED), w_b};
    end
  end
  // level register: shifts on advance, holds on stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
`ifdef ADDER_TREE_ACCUM_EN
      o_last  <= 1'b0;
`endif
    end else if (advance) begin
      o_data  <= w_sum;
      o_valid <= i_valid;
`ifdef ADDER_TREE_ACCUM_EN
      o_last  <= i_last;
`endif
    end
  end
endmodule

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree: fully pipelined valid/ready adder tree with global stall; ADDER_TREE_ACCUM_EN adds a group accumulator
module pipelined_adder_tree #(
  parameter int N_INPUTS = 8,
  parameter int IN_WIDTH = 23,
  parameter bit SIGNED   = 1'b0
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_adder_tree_if.slave  bus
);
  import adder_tree_pkg::*;
  localparam int LEVELS = $clog2(N_INPUTS);
  localparam int TREE_W = IN_WIDTH + LEVELS;
  logic                         w_advance;
  logic [N_INPUTS*IN_WIDTH-1:0] r_data0;
  logic                         r_valid0;
  logic [TREE_W-1:0]            w_tree;
  logic                         w_tree_valid;
`ifdef ADDER_TREE_ACCUM_EN
  localparam int OUT_WIDTH = TREE_W + ACC_BITS;
  logic r_last0;
  logic w_tree_last;
`endif
  assign w_advance   = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_advance;
  // stage 0: register the operand vector (or a bubble) on every advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data0  <= '0;
      r_valid0 <= 1'b0;
`ifdef ADDER_TREE_ACCUM_EN
      r_last0  <= 1'b0;
`endif
    end else if (w_advance) begin
      r_data0  <= bus.in_data;
      r_valid0 <= bus.in_valid;
`ifdef ADDER_TREE_ACCUM_EN
      r_last0  <= bus.in_last;
`endif
    end
  end
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NI = stage_ops(N_INPUTS, k-1);
    localparam int WI = IN_WIDTH + k - 1;
    logic [NI*WI-1:0]          w_in;
    logic                      w_vin;
    logic [(NI/2)*(WI+1)-1:0]  w_out;
    logic                      w_vout;
`ifdef ADDER_TREE_ACCUM_EN
    logic w_lin;
    logic w_lout;
`endif
    if (k == 1) begin : g_src
      assign w_in  = r_data0;
      assign w_vin = r_valid0;
`ifdef ADDER_TREE_ACCUM_EN
      assign w_lin = r_last0;
`endif
    end else begin : g_src
      assign w_in  = g_lvl[k-1].w_out;
      assign w_vin = g_lvl[k-1].w_vout;
`ifdef ADDER_TREE_ACCUM_EN
      assign w_lin = g_lvl[k-1].w_lout;
`endif
    end
    adder_tree_level #(.N_IN(NI), .W(WI), .SIGNED(SIGNED)) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (w_advance),
      .i_data  (w_in),
      .i_valid (w_vin),
`ifdef ADDER_TREE_ACCUM_EN
      .i_last  (w_lin),
      .o_last  (w_lout),
`endif
      .o_data  (w_out),
      .o_valid (w_vout)
    );
  end
  assign w_tree       = g_lvl[LEVELS].w_out;
  assign w_tree_valid = g_lvl[LEVELS].w_vout;
`ifdef ADDER_TREE_ACCUM_EN
  assign w_tree_last  = g_lvl[LEVELS].w_lout;
  logic [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0] r_sum;
  logic [OUT_WIDTH-1:0] w_ext;
  logic                 r_out_valid;
  assign w_ext = {{ACC_BITS{ext(w_tree[TREE_W-1], SIGNED)}}, w_tree};
  // fold tree results into the group total; publish and restart from 0 on the last one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= w_tree_valid && w_tree_last;
      if (w_tree_valid) begin
        r_acc <= w_tree_last ? '0 : r_acc + w_ext;
        if (w_tree_last) r_sum <= r_acc + w_ext;
      end
    end
  end
  assign bus.out_sum   = r_sum;
  assign bus.out_valid = r_out_valid;
`else
  assign bus.out_sum   = w_tree;
  assign bus.out_valid = w_tree_valid;
`endif
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// tb_pipelined_adder_tree: scoreboard bench for unsigned and signed trees (ADDER_TREE_ACCUM_EN adds a group test)
module tb_pipelined_adder_tree;
  import adder_tree_pkg::*;
  localparam int N = 8;
  localparam int IW = 23;
  localparam int LEVELS = $clog2(N);
`ifdef ADDER_TREE_ACCUM_EN
  localparam int OUT_W = IW + LEVELS + ACC_BITS;
  localparam int LAT = LEVELS + 2;
`else
  localparam int OUT_W = IW + LEVELS;
  localparam int LAT = LEVELS + 1;
`endif
  typedef logic [N*IW-1:0] vec_t;
  typedef logic [OUT_W-1:0] sum_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int n_out = 0;
  sum_t qu[$];
  sum_t qs[$];
  sum_t acc_m = '0;
  sum_t mon_exp;
  logic prev_stall = 1'b0;
  sum_t prev_sum = '0;
  always #5 clk = ~clk;
  pipelined_adder_tree_if #(.N_INPUTS(N), .IN_WIDTH(IW)) ifu ();
  pipelined_adder_tree_if #(.N_INPUTS(N), .IN_WIDTH(IW)) ifs ();
  pipelined_adder_tree #(.N_INPUTS(N), .IN_WIDTH(IW), .SIGNED(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(ifu));
  pipelined_adder_tree #(.N_INPUTS(N), .IN_WIDTH(IW), .SIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs));
  function automatic sum_t model(input vec_t d, input bit s);
    longint acc;
    logic [IW-1:0] v;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      v = d[i*IW +: IW];
      acc += s ? longint'($signed(v)) : longint'(v);
    end
    return acc[OUT_W-1:0];
  endfunction
  function automatic vec_t pack(input int a[N]);
    vec_t d;
    logic [31:0] t;
    for (int i = 0; i < N; i++) begin
      t = a[i];
      d[i*IW +: IW] = t[IW-1:0];
    end
    return d;
  endfunction
  function automatic vec_t rvec();
    vec_t d;
    logic [31:0] r;
    for (int i = 0; i < N; i++) begin
      r = $urandom();
      d[i*IW +: IW] = r[IW-1:0];
    end
    return d;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // scoreboard and protocol monitor for the unsigned tree, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      qu.delete();
      acc_m = '0;
    end else begin
      n_tests++;
      if (ifu.in_ready !== (!ifu.out_valid || ifu.out_ready)) begin
        n_fail++;
        $display("FAIL in_ready: got %b want %b", ifu.in_ready, !ifu.out_valid || ifu.out_ready);
      end
      if (prev_stall) begin
        n_tests++;
        if (ifu.out_valid !== 1'b1 || ifu.out_sum !== prev_sum) begin
          n_fail++;
          $display("FAIL stall_hold: got valid %b sum %0h want valid 1 sum %0h", ifu.out_valid, ifu.out_sum, prev_sum);
        end
      end
      if (ifu.in_valid && ifu.in_ready) begin
`ifdef ADDER_TREE_ACCUM_EN
        acc_m = acc_m + model(ifu.in_data, 1'b0);
        if (ifu.in_last) begin
          qu.push_back(acc_m);
          acc_m = '0;
        end
`else
        qu.push_back(model(ifu.in_data, 1'b0));
`endif
      end
      if (ifu.out_valid && ifu.out_ready) begin
        n_out++;
        n_tests++;
        if (qu.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %0h want none", ifu.out_sum);
        end else begin
          mon_exp = qu.pop_front();
          if (ifu.out_sum !== mon_exp) begin
            n_fail++;
            $display("FAIL scoreboard: got %0h want %0h", ifu.out_sum, mon_exp);
          end
        end
      end
    end
    prev_stall = rst_n && ifu.out_valid && !ifu.out_ready;
    prev_sum = ifu.out_sum;
  end
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_tests++;
    if (ifu.out_valid !== 1'b0 || ifu.out_sum !== '0) begin
      n_fail++;
      $display("FAIL reset_u: got valid %b sum %0h want 0 0", ifu.out_valid, ifu.out_sum);
    end
    n_tests++;
    if (ifs.out_valid !== 1'b0 || ifs.out_sum !== '0) begin
      n_fail++;
      $display("FAIL reset_s: got valid %b sum %0h want 0 0", ifs.out_valid, ifs.out_sum);
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if (ifu.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", ifu.in_ready);
    end
  endtask
  task automatic test_basic();
    int arr[N];
    arr = '{1, 2, 3, 4, 5, 6, 7, 8};
    ifu.out_ready = 1'b1;
    ifu.in_data = pack(arr);
    ifu.in_valid = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      step();
      if (c == 1) ifu.in_valid = 1'b0;
      n_tests++;
      if (ifu.out_valid !== (c == LAT)) begin
        n_fail++;
        $display("FAIL latency c=%0d: got valid %b want %b", c, ifu.out_valid, c == LAT);
      end
      if (c == LAT) begin
        n_tests++;
        if (ifu.out_sum !== sum_t'(36)) begin
          n_fail++;
          $display("FAIL basic_sum: got %0d want 36", ifu.out_sum);
        end
      end
    end
  endtask
  task automatic test_max();
    int k;
    ifu.in_data = '1;
    ifu.in_valid = 1'b1;
    step();
    ifu.in_valid = 1'b0;
    k = 0;
    while (!ifu.out_valid && k < 10) begin
      step();
      k++;
    end
    n_tests++;
    if (ifu.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL max_timeout: got no valid want valid");
    end else if (ifu.out_sum !== sum_t'(26'h3FFFFF8)) begin
      n_fail++;
      $display("FAIL max_sum: got %0h want 3fffff8", ifu.out_sum);
    end
    step();
  endtask
  task automatic test_signed();
    int arr[N];
    int got;
    sum_t e;
    arr = '{-5, 3, 7, -100, 4194303, -4194304, 0, 1};
    ifs.out_ready = 1'b1;
    ifs.in_data = '1;
    qs.push_back(model(ifs.in_data, 1'b1));
    ifs.in_valid = 1'b1;
    step();
    ifs.in_data = pack(arr);
    qs.push_back(model(ifs.in_data, 1'b1));
    step();
    ifs.in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      step();
      if (ifs.out_valid && qs.size() > 0) begin
        e = qs.pop_front();
        n_tests++;
        if (ifs.out_sum !== e) begin
          n_fail++;
          $display("FAIL signed_model %0d: got %0h want %0h", got, ifs.out_sum, e);
        end
        if (got == 0) begin
          n_tests++;
          if (ifs.out_sum !== sum_t'(-8)) begin
            n_fail++;
            $display("FAIL signed_minus8: got %0h want %0h", ifs.out_sum, sum_t'(-8));
          end
        end
        got++;
      end
    end
    n_tests++;
    if (got != 2) begin
      n_fail++;
      $display("FAIL signed_count: got %0d want 2", got);
    end
  endtask
  task automatic test_backpressure();
    vec_t cur;
    int sent;
    int n0;
    sent = 0;
    n0 = n_out;
    cur = rvec();
    for (int c = 0; c < 600 && (sent < 20 || qu.size() > 0); c++) begin
      ifu.out_ready = 1'($urandom_range(0, 1));
      ifu.in_valid = (sent < 20);
      ifu.in_data = cur;
      @(negedge clk);
      if (ifu.in_valid && ifu.in_ready) begin
        sent++;
        cur = rvec();
      end
      step();
    end
    ifu.in_valid = 1'b0;
    ifu.out_ready = 1'b1;
    n_tests++;
    if (n_out - n0 != 20 || qu.size() != 0) begin
      n_fail++;
      $display("FAIL backpressure: got %0d outputs %0d pending want 20 0", n_out - n0, qu.size());
    end
  endtask
  task automatic test_reset_mid();
    ifu.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ifu.in_data = rvec();
      ifu.in_valid = 1'b1;
      step();
    end
    ifu.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_tests++;
    if (ifu.out_valid !== 1'b0 || ifu.out_sum !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid %b sum %0h want 0 0", ifu.out_valid, ifu.out_sum);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++;
      if (ifu.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale c=%0d: got valid %b want 0", c, ifu.out_valid);
      end
    end
  endtask
`ifdef ADDER_TREE_ACCUM_EN
  task automatic test_accum();
    int arr[N];
    int grp[2];
    int hits;
    arr = '{1, 1, 1, 1, 1, 1, 1, 1};
    grp = '{3, 1};
    ifu.out_ready = 1'b1;
    ifu.in_data = pack(arr);
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < grp[g]; k++) begin
        ifu.in_last = (k == grp[g] - 1);
        ifu.in_valid = 1'b1;
        step();
      end
      ifu.in_valid = 1'b0;
      ifu.in_last = 1'b1;
      hits = 0;
      for (int c = 0; c < 10; c++) begin
        step();
        if (ifu.out_valid) begin
          hits++;
          n_tests++;
          if (ifu.out_sum !== sum_t'(8 * grp[g])) begin
            n_fail++;
            $display("FAIL accum_sum g=%0d: got %0d want %0d", g, ifu.out_sum, 8 * grp[g]);
          end
        end
      end
      n_tests++;
      if (hits != 1) begin
        n_fail++;
        $display("FAIL accum_pulses g=%0d: got %0d want 1", g, hits);
      end
    end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    ifu.in_valid = 1'b0;
    ifu.in_data = '0;
    ifu.out_ready = 1'b1;
    ifs.in_valid = 1'b0;
    ifs.in_data = '0;
    ifs.out_ready = 1'b1;
`ifdef ADDER_TREE_ACCUM_EN
    ifu.in_last = 1'b1;
    ifs.in_last = 1'b1;
`endif
    test_reset();
    test_basic();
    test_max();
    test_signed();
    test_backpressure();
    test_reset_mid();
`ifdef ADDER_TREE_ACCUM_EN
    test_accum();
`endif
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
